// File: rtl/wb_stage.sv
// Writeback pipeline stage: registers M-stage fields, selects writeback data, counts retired instructions.
// Optional sub-word load extraction/extension is built only when WB_LOAD_EXT_EN is defined.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_mem,
    input  logic [31:0] m_mdu,
    input  logic [1:0]  m_wsel,
    input  logic [2:0]  m_ldtype,
    input  logic [1:0]  m_byteoff,
    input  logic        m_we,
    input  logic [4:0]  m_wa,
    output logic [31:0] w_pc,
    output logic        w_we,
    output logic [4:0]  w_wa,
    output logic [31:0] w_wd,
    output logic        w_valid,
    output logic [31:0] w_retired
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RAW   = 5;
    localparam int unsigned SELW  = 2;
    localparam int unsigned LDW   = 3;
    localparam int unsigned OFFW  = 2;

    localparam logic [SELW-1:0] SEL_ALU = 2'b00;
    localparam logic [SELW-1:0] SEL_MEM = 2'b01;
    localparam logic [SELW-1:0] SEL_PC8 = 2'b10;

    logic            valid_q, valid_d;
    logic            we_q, we_d;
    logic [RAW-1:0]  wa_q, wa_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] mem_q, mem_d;
    logic [XLEN-1:0] mdu_q, mdu_d;
    logic [XLEN-1:0] retired_q, retired_d;
    logic [XLEN-1:0] mem_val;

`ifdef WB_LOAD_EXT_EN
    logic [LDW-1:0]  ldtype_q, ldtype_d;
    logic [OFFW-1:0] byteoff_q, byteoff_d;
`else
    logic unused_ldinfo;
    assign unused_ldinfo = ^{m_ldtype, m_byteoff};
`endif

    // Next-state: flush beats capture, en=0 holds.
    always_comb begin
        valid_d   = valid_q;
        we_d      = we_q;
        wa_d      = wa_q;
        pc_d      = pc_q;
        sel_d     = sel_q;
        alu_d     = alu_q;
        mem_d     = mem_q;
        mdu_d     = mdu_q;
        retired_d = retired_q;
`ifdef WB_LOAD_EXT_EN
        ldtype_d  = ldtype_q;
        byteoff_d = byteoff_q;
`endif
        if (flush) begin
            valid_d   = 1'b0;
            we_d      = 1'b0;
            wa_d      = '0;
            pc_d      = '0;
            sel_d     = SEL_ALU;
            alu_d     = '0;
            mem_d     = '0;
            mdu_d     = '0;
`ifdef WB_LOAD_EXT_EN
            ldtype_d  = '0;
            byteoff_d = '0;
`endif
        end else if (en) begin
            valid_d   = m_valid;
            we_d      = m_we;
            wa_d      = m_wa;
            pc_d      = m_pc;
            sel_d     = m_wsel;
            alu_d     = m_alu;
            mem_d     = m_mem;
            mdu_d     = m_mdu;
`ifdef WB_LOAD_EXT_EN
            ldtype_d  = m_ldtype;
            byteoff_d = m_byteoff;
`endif
            if (m_valid) begin
                retired_d = retired_q + XLEN'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            pc_q      <= '0;
            sel_q     <= SEL_ALU;
            alu_q     <= '0;
            mem_q     <= '0;
            mdu_q     <= '0;
            retired_q <= '0;
`ifdef WB_LOAD_EXT_EN
            ldtype_q  <= '0;
            byteoff_q <= '0;
`endif
        end else begin
            valid_q   <= valid_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            pc_q      <= pc_d;
            sel_q     <= sel_d;
            alu_q     <= alu_d;
            mem_q     <= mem_d;
            mdu_q     <= mdu_d;
            retired_q <= retired_d;
`ifdef WB_LOAD_EXT_EN
            ldtype_q  <= ldtype_d;
            byteoff_q <= byteoff_d;
`endif
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Halfword lane uses byteoff[1] only; odd offsets are not trapped.
    always_comb begin
        lane_b  = 8'(mem_q >> {byteoff_q, 3'b000});
        lane_h  = byteoff_q[1] ? mem_q[31:16] : mem_q[15:0];
        case (ldtype_q)
            3'b001:  mem_val = {{24{lane_b[7]}}, lane_b};
            3'b010:  mem_val = {24'h000000, lane_b};
            3'b011:  mem_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  mem_val = {16'h0000, lane_h};
            default: mem_val = mem_q;
        endcase
    end
`else
    assign mem_val = mem_q;
`endif

    // Writeback data mux; bubbles drive zero.
    always_comb begin
        w_wd = '0;
        if (valid_q) begin
            case (sel_q)
                SEL_ALU: w_wd = alu_q;
                SEL_MEM: w_wd = mem_val;
                SEL_PC8: w_wd = pc_q + XLEN'(8);
                default: w_wd = mdu_q;
            endcase
        end
    end

    assign w_we      = valid_q & we_q & (wa_q != '0);
    assign w_wa      = wa_q;
    assign w_pc      = pc_q;
    assign w_valid   = valid_q;
    assign w_retired = retired_q;

endmodule
